// File: rtl/brc_iter.sv
// ----------------------------------------------------------------------------
// brc_iter : multi-cycle branch comparator.
//   Compares two WIDTH-bit operands SLICE bits per cycle, most significant
//   slice first, in signed or unsigned mode. When EARLY_OUT is set it stops at
//   the first differing slice. Otherwise it always scans every slice.
//   Requests and results each use a valid/ready handshake.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_flush                 kill the in-flight compare / block acceptance
//   i_valid, o_ready        request handshake (o_ready high only in IDLE)
//   i_rs1_data, i_rs2_data  operands A and B
//   i_br_un                 1 = unsigned, 0 = signed compare
//   o_valid, i_ready        result handshake
//   o_br_less, o_br_equal   registered result (A < B, A == B)
// ----------------------------------------------------------------------------
module brc_iter #(
   parameter int WIDTH     = 32,
   parameter int SLICE     = 8,
   parameter int EARLY_OUT = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_rs1_data,
   input  logic [WIDTH-1:0] i_rs2_data,
   input  logic             i_br_un,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_br_less,
   output logic             o_br_equal
);

   localparam int NSLICE = (SLICE < 1) ? 1 : (WIDTH / SLICE);
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam bit EO     = (EARLY_OUT != 0);

   if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
      $error("brc_iter: WIDTH must be a positive multiple of SLICE");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_un;
   logic [IDXW-1:0]    r_idx;
   logic               r_found;      // a difference was already seen (EARLY_OUT=0)
   logic               r_fless;      // less-than of that first difference
   logic               r_less;
   logic               r_equal;
   logic               r_ready;
   logic               r_valid;
   logic [SLICE-1:0]   w_a_slice;
   logic [SLICE-1:0]   w_b_slice;
   logic               w_diff;
   logic               w_lt;
   logic               w_last;
   logic               w_ready_nx;
   logic               w_valid_nx;
   int                 w_base;

   // Slice select and compare of the latched operands.
   always_comb begin
      w_base    = int'(r_idx) * SLICE;
      w_a_slice = r_a[w_base +: SLICE];
      w_b_slice = r_b[w_base +: SLICE];
      // Signed compare: flipping the sign bit of the top slice turns
      // two's-complement order into plain unsigned order.
      if (!r_un && (r_idx == IDXW'(NSLICE - 1))) begin
         w_a_slice[SLICE-1] = ~w_a_slice[SLICE-1];
         w_b_slice[SLICE-1] = ~w_b_slice[SLICE-1];
      end else begin
         w_a_slice = w_a_slice;
      end
      w_diff = (w_a_slice != w_b_slice);
      w_lt   = (w_a_slice <  w_b_slice);
      w_last = (r_idx == IDXW'(0));
   end

   // State register plus registered handshake outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= w_ready_nx;
         r_valid <= w_valid_nx;
      end
   end

   // Next-state logic; flush forces IDLE from any state.
   always_comb begin
      w_next = r_state;
      if (i_flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) w_next = S_CMP;
               else         w_next = S_IDLE;
            end
            S_CMP: begin
               if ((w_diff && EO) || w_last) w_next = S_DONE;
               else                          w_next = S_CMP;
            end
            S_DONE: begin
               if (i_ready) w_next = S_IDLE;
               else         w_next = S_DONE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from the next state so they leave a flop.
   always_comb begin
      w_ready_nx = 1'b0;
      w_valid_nx = 1'b0;
      case (w_next)
         S_IDLE:  w_ready_nx = 1'b1;
         S_DONE:  w_valid_nx = 1'b1;
         default: w_ready_nx = 1'b0;
      endcase
   end

   // Operand capture, slice walk and result registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_un    <= 1'b0;
         r_idx   <= '0;
         r_found <= 1'b0;
         r_fless <= 1'b0;
         r_less  <= 1'b0;
         r_equal <= 1'b0;
      end else if (!i_flush) begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  r_a     <= i_rs1_data;
                  r_b     <= i_rs2_data;
                  r_un    <= i_br_un;
                  r_idx   <= IDXW'(NSLICE - 1);
                  r_found <= 1'b0;
                  r_fless <= 1'b0;
               end
            end
            S_CMP: begin
               if (w_diff && EO) begin
                  r_less  <= w_lt;
                  r_equal <= 1'b0;
               end else if (w_last) begin
                  // Highest differing slice decides; none means equal.
                  if (r_found) begin
                     r_less  <= r_fless;
                     r_equal <= 1'b0;
                  end else if (w_diff) begin
                     r_less  <= w_lt;
                     r_equal <= 1'b0;
                  end else begin
                     r_less  <= 1'b0;
                     r_equal <= 1'b1;
                  end
               end else begin
                  if (w_diff && !r_found) begin
                     r_found <= 1'b1;
                     r_fless <= w_lt;
                  end
                  r_idx <= r_idx - 1'b1;
               end
            end
            default: r_idx <= r_idx;
         endcase
      end
   end

   assign o_ready    = r_ready;
   assign o_valid    = r_valid;
   assign o_br_less  = r_less;
   assign o_br_equal = r_equal;

endmodule

// File: tb/tb_brc_iter.sv
// Directed bench for brc_iter: unit 0 is the default build (SLICE=8,
// EARLY_OUT=1), unit 1 uses EARLY_OUT=0, unit 2 uses SLICE=32.
module tb_brc_iter;

   logic        clk;
   logic        rst;
   logic [2:0]  flush;
   logic [2:0]  vld_in;
   logic [2:0]  rdy_in;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        br_un;
   logic [2:0]  rdy_out;
   logic [2:0]  vld_out;
   logic [2:0]  less_out;
   logic [2:0]  eq_out;

   int total;
   int bad;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        un;
      logic        less;
      logic        equal;
      int          lat;
   } vec_t;

   vec_t vecs [0:9];

   brc_iter #(.WIDTH(32), .SLICE(8), .EARLY_OUT(1)) u0 (
      .i_clk(clk), .i_reset(rst), .i_flush(flush[0]), .i_valid(vld_in[0]),
      .o_ready(rdy_out[0]), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un),
      .o_valid(vld_out[0]), .i_ready(rdy_in[0]), .o_br_less(less_out[0]),
      .o_br_equal(eq_out[0]));

   brc_iter #(.WIDTH(32), .SLICE(8), .EARLY_OUT(0)) u1 (
      .i_clk(clk), .i_reset(rst), .i_flush(flush[1]), .i_valid(vld_in[1]),
      .o_ready(rdy_out[1]), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un),
      .o_valid(vld_out[1]), .i_ready(rdy_in[1]), .o_br_less(less_out[1]),
      .o_br_equal(eq_out[1]));

   brc_iter #(.WIDTH(32), .SLICE(32), .EARLY_OUT(1)) u2 (
      .i_clk(clk), .i_reset(rst), .i_flush(flush[2]), .i_valid(vld_in[2]),
      .o_ready(rdy_out[2]), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un),
      .o_valid(vld_out[2]), .i_ready(rdy_in[2]), .o_br_less(less_out[2]),
      .o_br_equal(eq_out[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: less-than under the selected mode.
   function automatic logic ref_less(input logic [31:0] a, input logic [31:0] b,
                                     input logic un);
      if (un) return (a < b);
      else    return ($signed(a) < $signed(b));
   endfunction

   // Expected accept-to-valid latency per unit.
   function automatic int ref_lat(input int u, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x;
      x = a ^ b;
      if (u == 2) return 2;
      if (u == 1) return 5;
      for (int s = 3; s >= 0; s--) begin
         if (x[s*8 +: 8] != 8'd0) return (4 - s) + 1;
      end
      return 5;
   endfunction

   // One full transaction on unit u; hold = cycles to keep i_ready low in DONE.
   task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                         input logic un, input logic e_less, input logic e_eq,
                         input int e_lat, input int hold);
      int cyc;
      check("ready_before_op", int'(rdy_out[u]), 1);
      rs1 = a; rs2 = b; br_un = un;
      vld_in[u] = 1'b1;
      tick();
      vld_in[u] = 1'b0;
      rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D; br_un = ~un;
      cyc = 1;
      while (!vld_out[u] && cyc < 50) begin
         tick();
         cyc++;
      end
      check("latency", cyc, e_lat);
      check("less", int'(less_out[u]), int'(e_less));
      check("equal", int'(eq_out[u]), int'(e_eq));
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", int'(vld_out[u]), 1);
         check("hold_ready", int'(rdy_out[u]), 0);
         check("hold_less", int'(less_out[u]), int'(e_less));
         check("hold_equal", int'(eq_out[u]), int'(e_eq));
      end
      rdy_in[u] = 1'b1;
      tick();
      rdy_in[u] = 1'b0;
      check("valid_after_hs", int'(vld_out[u]), 0);
      check("ready_after_hs", int'(rdy_out[u]), 1);
      check("less_held_idle", int'(less_out[u]), int'(e_less));
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        ru;
      logic        el;
      logic        ee;
      logic        pl;
      logic        pe;
      int          seen;

      total = 0; bad = 0;
      rst = 1'b1; flush = 3'b000; vld_in = 3'b000; rdy_in = 3'b000;
      rs1 = 32'd0; rs2 = 32'd0; br_un = 1'b0;

      vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 5};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 2};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 5};
      vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 5};
      vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2};
      vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 2};
      vecs[7] = '{32'h0001_0000, 32'h0002_0000, 1'b0, 1'b1, 1'b0, 3};
      vecs[8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5};
      vecs[9] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5};

      tick(); tick();
      rst = 1'b0;
      check("rst_ready", int'(rdy_out[0]), 1);
      check("rst_valid", int'(vld_out[0]), 0);
      check("rst_less", int'(less_out[0]), 0);
      check("rst_equal", int'(eq_out[0]), 0);

      // Directed table on the early-out unit.
      for (int i = 0; i < 10; i++) begin
         run_op(0, vecs[i].a, vecs[i].b, vecs[i].un, vecs[i].less,
                vecs[i].equal, vecs[i].lat, 0);
      end

      // Back-pressure: result held for three cycles.
      run_op(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 1'b0, 5, 3);

      // Full-scan unit and single-slice unit on the case-2 operands.
      run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 5, 0);
      run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 5, 0);
      run_op(1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 5, 0);
      run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 2, 0);
      run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2, 0);

      // Flush in the 2nd CMP cycle: no result, back to IDLE, results kept.
      pl = less_out[0]; pe = eq_out[0];
      rs1 = 32'h0000_0001; rs2 = 32'h0000_0001; br_un = 1'b1;
      vld_in[0] = 1'b1;
      tick();
      vld_in[0] = 1'b0;
      tick();
      flush[0] = 1'b1;
      tick();
      flush[0] = 1'b0;
      check("flush_ready", int'(rdy_out[0]), 1);
      check("flush_valid", int'(vld_out[0]), 0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (vld_out[0]) seen++;
      end
      check("flush_no_valid", seen, 0);
      check("flush_less_kept", int'(less_out[0]), int'(pl));
      check("flush_equal_kept", int'(eq_out[0]), int'(pe));

      // Flush in IDLE blocks acceptance.
      vld_in[0] = 1'b1; flush[0] = 1'b1;
      tick();
      vld_in[0] = 1'b0; flush[0] = 1'b0;
      check("idle_flush_ready", int'(rdy_out[0]), 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (vld_out[0]) seen++;
      end
      check("idle_flush_no_valid", seen, 0);

      // Reset mid-compare after a result left less=1 in the registers.
      run_op(0, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 5, 0);
      rs1 = 32'h0000_0003; rs2 = 32'h0000_0003; br_un = 1'b0;
      vld_in[0] = 1'b1;
      tick();
      vld_in[0] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_ready", int'(rdy_out[0]), 1);
      check("mid_rst_valid", int'(vld_out[0]), 0);
      check("mid_rst_less", int'(less_out[0]), 0);
      check("mid_rst_equal", int'(eq_out[0]), 0);

      // Random sweep on all three builds against the reference model.
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 3 == 1) rb = ra ^ (32'd1 << $urandom_range(31, 0));
         if (i % 6 == 2) rb = ra;
         ru = 1'(i % 2);
         el = ref_less(ra, rb, ru);
         ee = (ra == rb);
         run_op(i % 3, ra, rb, ru, el, ee, ref_lat(i % 3, ra, rb), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
